// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types, defaults and helpers for stream_demux
package demux_pkg;

    // Packet-level routing state: waiting for a first beat, forwarding to a
    // latched port, or discarding a packet whose destination was invalid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam int CNT_W_DEFAULT = 16;

    // Width of a binary index able to address n ports.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_out_stage.sv
// rtl/demux_out_stage.sv - one-entry output register slice with one-hot valid decode
module demux_out_stage #(
    parameter int PORT_COUNT = 4,
    parameter int BIT_WIDTH  = 8,
    parameter int SEL_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BIT_WIDTH-1:0]  in_data,
    input  logic                  in_last,
    input  logic [SEL_W-1:0]      in_dest,
    input  logic [PORT_COUNT-1:0] m_ready,
    output logic                  full,
    output logic                  drain,
    output logic [PORT_COUNT-1:0] m_valid,
    output logic [BIT_WIDTH-1:0]  m_data,
    output logic                  m_last
);

    logic [SEL_W-1:0] dest;

    // Entry register: a load always wins because the top only loads when the
    // slot is empty or is draining in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            full   <= 1'b0;
            m_data <= '0;
            m_last <= 1'b0;
            dest   <= '0;
        end else if (load) begin
            full   <= 1'b1;
            m_data <= in_data;
            m_last <= in_last;
            dest   <= in_dest;
        end else if (drain) begin
            full   <= 1'b0;
        end
    end

    // Decode the held destination into a one-hot valid vector.
    always_comb begin
        m_valid = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            m_valid[i] = full && (dest == SEL_W'(i));
        end
    end

    // Only the addressed port's ready can release the entry.
    assign drain = |(m_valid & m_ready);

endmodule

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - packet-aware 1-to-N stream demultiplexer with registered outputs
module stream_demux
    import demux_pkg::*;
#(
    parameter int PORT_COUNT = 4,
    parameter int BIT_WIDTH  = 8,
    parameter int SEL_W      = sel_width(PORT_COUNT),
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [BIT_WIDTH-1:0]  s_data,
    input  logic                  s_last,
    input  logic [SEL_W-1:0]      s_sel,
    output logic [PORT_COUNT-1:0] m_valid,
    input  logic [PORT_COUNT-1:0] m_ready,
    output logic [BIT_WIDTH-1:0]  m_data,
    output logic                  m_last,
    output logic [CNT_W-1:0]      drop_count,
    output logic                  busy
);

    localparam logic [SEL_W:0] PORT_LIMIT = (SEL_W+1)'(PORT_COUNT);

    state_t           state;
    state_t           state_next;
    logic [SEL_W-1:0] route;
    logic             full;
    logic             drain;
    logic             accept;
    logic             in_range;
    logic             load;
    logic             drop;
    logic [SEL_W-1:0] dest_in;

    assign in_range = ({1'b0, s_sel} < PORT_LIMIT);
    // DROP never touches the out reg, so it can always swallow beats.
    assign s_ready  = (state == DROP) ? 1'b1 : (!full || drain);
    assign accept   = s_valid && s_ready;
    assign dest_in  = (state == FWD) ? route : s_sel;
    assign busy     = (state != IDLE) || full;

    // Next-state and per-beat load/drop decisions.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load = in_range;
                    drop = !in_range;
                    if (!s_last) begin
                        state_next = in_range ? FWD : DROP;
                    end
                end
            end
            FWD: begin
                if (accept) begin
                    load = 1'b1;
                    if (s_last) begin
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                if (accept) begin
                    drop = 1'b1;
                    if (s_last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and route latch; the route is captured on a valid first beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            route <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && accept && in_range) begin
                route <= s_sel;
            end
        end
    end

    // Saturating count of discarded beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop && (drop_count != {CNT_W{1'b1}})) begin
            drop_count <= drop_count + CNT_W'(1);
        end
    end

    demux_out_stage #(
        .PORT_COUNT (PORT_COUNT),
        .BIT_WIDTH  (BIT_WIDTH),
        .SEL_W      (SEL_W)
    ) u_out_stage (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .in_data (s_data),
        .in_last (s_last),
        .in_dest (dest_in),
        .m_ready (m_ready),
        .full    (full),
        .drain   (drain),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last)
    );

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - scoreboard bench for stream_demux (4-port and 3-port instances)
module tb_stream_demux;

    typedef struct {
        int         port;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        s_valid4 = 1'b0, s_last4 = 1'b0, s_ready4;
    logic [7:0]  s_data4 = '0, m_data4;
    logic [1:0]  s_sel4 = '0;
    logic [3:0]  m_valid4, m_ready4 = 4'b1111;
    logic        m_last4, busy4;
    logic [15:0] drop_count4;

    logic        s_valid3 = 1'b0, s_last3 = 1'b0, s_ready3;
    logic [7:0]  s_data3 = '0, m_data3;
    logic [1:0]  s_sel3 = '0;
    logic [2:0]  m_valid3, m_ready3 = 3'b111;
    logic        m_last3, busy3;
    logic [15:0] drop_count3;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    exp_t exp4[$];
    exp_t exp3[$];
    int xfer4[$];

    stream_demux #(.PORT_COUNT(4), .BIT_WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4),
        .s_last(s_last4), .s_sel(s_sel4),
        .m_valid(m_valid4), .m_ready(m_ready4), .m_data(m_data4),
        .m_last(m_last4), .drop_count(drop_count4), .busy(busy4)
    );

    stream_demux #(.PORT_COUNT(3), .BIT_WIDTH(8), .CNT_W(16)) dut3 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3),
        .s_last(s_last3), .s_sel(s_sel3),
        .m_valid(m_valid3), .m_ready(m_ready3), .m_data(m_data3),
        .m_last(m_last3), .drop_count(drop_count3), .busy(busy3)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every output handshake is popped against the expected queue.
    always @(negedge clk) begin
        if (!rst && (m_valid4 & m_ready4) != 4'b0000) begin
            exp_t e;
            logic [3:0] want_v;
            n_checks++;
            if (exp4.size() == 0) begin
                n_errors++;
                $display("FAIL sb4_unexpected: got valid=%b data=%h, expected no beat", m_valid4, m_data4);
            end else begin
                e = exp4.pop_front();
                want_v = 4'b0001 << e.port;
                xfer4.push_back(cyc);
                if (m_valid4 !== want_v || m_data4 !== e.data || m_last4 !== e.last) begin
                    n_errors++;
                    $display("FAIL sb4_beat: got valid=%b data=%h last=%b, expected valid=%b data=%h last=%b",
                             m_valid4, m_data4, m_last4, want_v, e.data, e.last);
                end
            end
        end
        if (!rst && (m_valid3 & m_ready3) != 3'b000) begin
            exp_t e;
            logic [2:0] want_v;
            n_checks++;
            if (exp3.size() == 0) begin
                n_errors++;
                $display("FAIL sb3_unexpected: got valid=%b data=%h, expected no beat", m_valid3, m_data3);
            end else begin
                e = exp3.pop_front();
                want_v = 3'b001 << e.port;
                if (m_valid3 !== want_v || m_data3 !== e.data || m_last3 !== e.last) begin
                    n_errors++;
                    $display("FAIL sb3_beat: got valid=%b data=%h last=%b, expected valid=%b data=%h last=%b",
                             m_valid3, m_data3, m_last3, want_v, e.data, e.last);
                end
            end
        end
    end

    // Drive one beat, wait (bounded) for acceptance, push the expected output.
    // port < 0 means the beat must be dropped.
    task automatic send(input int which, input logic [7:0] d, input logic l,
                        input logic [1:0] sel, input int port, output int waits);
        exp_t e;
        bit   ok;
        if (which == 4) begin
            s_valid4 = 1'b1; s_data4 = d; s_last4 = l; s_sel4 = sel;
        end else begin
            s_valid3 = 1'b1; s_data3 = d; s_last3 = l; s_sel3 = sel;
        end
        waits = 0;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if ((which == 4) ? s_ready4 : s_ready3) begin
                ok = 1'b1;
                break;
            end
            waits++;
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got s_ready=0 for 60 cycles, expected acceptance of %h", d);
        end
        @(posedge clk);
        if (port >= 0) begin
            e.port = port; e.data = d; e.last = l;
            if (which == 4) exp4.push_back(e);
            else exp3.push_back(e);
        end
        #1;
        s_valid4 = 1'b0;
        s_valid3 = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (exp4.size() == 0 && exp3.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL drain: got %0d/%0d beats pending, expected 0", exp4.size(), exp3.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (m_valid4 !== 4'b0000 || m_data4 !== 8'h00 || m_last4 !== 1'b0 ||
            drop_count4 !== 16'd0 || busy4 !== 1'b0 || s_ready4 !== 1'b1) begin
            n_errors++;
            $display("FAIL reset4: got valid=%b data=%h last=%b drop=%0d busy=%b ready=%b, expected 0000 00 0 0 0 1",
                     m_valid4, m_data4, m_last4, drop_count4, busy4, s_ready4);
        end
        n_checks++;
        if (m_valid3 !== 3'b000 || drop_count3 !== 16'd0 || busy3 !== 1'b0 || s_ready3 !== 1'b1) begin
            n_errors++;
            $display("FAIL reset3: got valid=%b drop=%0d busy=%b ready=%b, expected 000 0 0 1",
                     m_valid3, drop_count3, busy3, s_ready3);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_packet();
        int w1, w2, w3;
        xfer4.delete();
        m_ready4 = 4'b1111;
        send(4, 8'h11, 1'b0, 2'd2, 2, w1);
        send(4, 8'h22, 1'b0, 2'd2, 2, w2);
        send(4, 8'h33, 1'b1, 2'd2, 2, w3);
        wait_drain();
        n_checks++;
        if (w1 != 0 || w2 != 0 || w3 != 0) begin
            n_errors++;
            $display("FAIL basic_bubbles: got waits %0d/%0d/%0d, expected 0/0/0", w1, w2, w3);
        end
        n_checks++;
        if (xfer4.size() != 3 || xfer4[1] != xfer4[0] + 1 || xfer4[2] != xfer4[1] + 1) begin
            n_errors++;
            $display("FAIL basic_consecutive: got %0d transfers not on consecutive cycles, expected 3 consecutive",
                     xfer4.size());
        end
    endtask

    task automatic test_route_lock();
        int w;
        send(4, 8'h11, 1'b0, 2'd2, 2, w);
        send(4, 8'h22, 1'b0, 2'd0, 2, w);
        send(4, 8'h33, 1'b1, 2'd0, 2, w);
        wait_drain();
    endtask

    task automatic test_backpressure();
        int w;
        m_ready4 = 4'b0001;
        send(4, 8'h11, 1'b0, 2'd1, 1, w);
        s_valid4 = 1'b1; s_data4 = 8'h22; s_last4 = 1'b0; s_sel4 = 2'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (s_ready4 !== 1'b0 || m_data4 !== 8'h11 || m_valid4 !== 4'b0010 || busy4 !== 1'b1) begin
                n_errors++;
                $display("FAIL stall_%0d: got ready=%b data=%h valid=%b busy=%b, expected 0 11 0010 1",
                         k, s_ready4, m_data4, m_valid4, busy4);
            end
        end
        @(posedge clk);
        #1 m_ready4 = 4'b0011;
        send(4, 8'h22, 1'b0, 2'd0, 1, w);
        n_checks++;
        if (w != 0) begin
            n_errors++;
            $display("FAIL stall_resume: got %0d wait cycles after ready, expected 0", w);
        end
        send(4, 8'h33, 1'b1, 2'd0, 1, w);
        wait_drain();
        m_ready4 = 4'b1111;
    endtask

    task automatic test_drop();
        int w1, w2, w3;
        send(3, 8'hAA, 1'b0, 2'd3, -1, w1);
        n_checks++;
        if (m_valid3 !== 3'b000) begin
            n_errors++;
            $display("FAIL drop_valid: got %b, expected 000", m_valid3);
        end
        send(3, 8'hBB, 1'b1, 2'd3, -1, w2);
        @(negedge clk);
        n_checks++;
        if (drop_count3 !== 16'd2 || m_valid3 !== 3'b000 || w1 != 0 || w2 != 0) begin
            n_errors++;
            $display("FAIL drop_count: got count=%0d valid=%b waits=%0d/%0d, expected 2 000 0/0",
                     drop_count3, m_valid3, w1, w2);
        end
        @(posedge clk);
        #1;
        send(3, 8'h5A, 1'b1, 2'd0, 0, w3);
        wait_drain();
        n_checks++;
        if (drop_count3 !== 16'd2) begin
            n_errors++;
            $display("FAIL drop_after: got count=%0d, expected 2", drop_count3);
        end
    endtask

    task automatic test_reset_mid_packet();
        int w;
        m_ready4 = 4'b0111;
        send(4, 8'h44, 1'b0, 2'd3, 3, w);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp4.delete();
        @(negedge clk);
        n_checks++;
        if (m_valid4 !== 4'b0000 || busy4 !== 1'b0 || s_ready4 !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_reset: got valid=%b busy=%b ready=%b, expected 0000 0 1",
                     m_valid4, busy4, s_ready4);
        end
        @(posedge clk);
        #1 m_ready4 = 4'b1111;
        send(4, 8'h55, 1'b1, 2'd1, 1, w);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int w[4];
        xfer4.delete();
        for (int i = 0; i < 4; i++) begin
            send(4, 8'hA0 + 8'(i), 1'b1, 2'(i), i, w[i]);
        end
        wait_drain();
        n_checks++;
        if (w[0] != 0 || w[1] != 0 || w[2] != 0 || w[3] != 0) begin
            n_errors++;
            $display("FAIL b2b_waits: got %0d/%0d/%0d/%0d, expected all 0", w[0], w[1], w[2], w[3]);
        end
        n_checks++;
        if (xfer4.size() != 4 || xfer4[3] != xfer4[0] + 3) begin
            n_errors++;
            $display("FAIL b2b_consecutive: got %0d transfers not back to back, expected 4 consecutive",
                     xfer4.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_route_lock();
        test_backpressure();
        test_drop();
        test_reset_mid_packet();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
